// File: rtl/gray_scale_pipe_if.sv
// Pixel stream bundle for gray_scale_pipe: RGB input side and gray output side.
// The slave modport is the converter; the master modport is its neighbour or a bench.
interface gray_scale_pipe_if #(
    parameter int unsigned CH_WIDTH  = 8,
    parameter int unsigned OUT_WIDTH = 8,
    parameter int unsigned CNT_WIDTH = 16
) ();
    logic                     in_valid_i;
    logic                     in_ready_o;
    logic                     in_sof_i;
    logic [3*CH_WIDTH-1:0]    in_px_rgb_i;
    logic [1:0]               mode_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic                     out_sof_o;
    logic [OUT_WIDTH-1:0]     out_px_gray_o;
    logic [CNT_WIDTH-1:0]     px_count_o;
    logic [1:0]               mode_o;

    modport slave (
        input  in_valid_i, in_sof_i, in_px_rgb_i, mode_i, out_ready_i,
        output in_ready_o, out_valid_o, out_sof_o, out_px_gray_o, px_count_o, mode_o
    );

    modport master (
        output in_valid_i, in_sof_i, in_px_rgb_i, mode_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_sof_o, out_px_gray_o, px_count_o, mode_o
    );
endinterface

// File: rtl/gray_scale_pipe.sv
// Two-stage RGB-to-gray converter with per-frame selectable luma weighting,
// valid/ready backpressure, SOF forwarding and a per-frame output pixel count.
module gray_scale_pipe #(
    parameter int unsigned CH_WIDTH  = 8,
    parameter int unsigned OUT_WIDTH = 8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input logic              clk_i,
    input logic              nreset_i,
    gray_scale_pipe_if.slave bus_io
);
    localparam int unsigned TW = CH_WIDTH + 2;
    localparam int unsigned SW = CH_WIDTH + 4;
    localparam int unsigned PW = SW + 7;
    localparam logic [PW-1:0] SAT_MAX = PW'((64'd1 << CH_WIDTH) - 64'd1);

    logic                 r_en;
    logic [1:0]           r_mode;
    logic                 r_s1_valid;
    logic                 r_s1_sof;
    logic                 r_s1_avg;
    logic [TW-1:0]        r_s1_tr;
    logic [TW-1:0]        r_s1_tg;
    logic [TW-1:0]        r_s1_tb;
    logic                 r_s2_valid;
    logic                 r_s2_sof;
    logic [OUT_WIDTH-1:0] r_s2_gray;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic                 w_s1_adv;
    logic                 w_in_ready;
    logic                 w_in_fire;
    logic                 w_out_fire;
    logic [1:0]           w_mode_eff;
    logic [TW-1:0]        w_r_x;
    logic [TW-1:0]        w_g_x;
    logic [TW-1:0]        w_b_x;
    logic [TW-1:0]        w_t_r;
    logic [TW-1:0]        w_t_g;
    logic [TW-1:0]        w_t_b;
    logic [SW-1:0]        w_sum;
    logic [PW-1:0]        w_avg_prod;
    logic [PW-1:0]        w_pre;
    logic [CH_WIDTH-1:0]  w_sat;
    logic [OUT_WIDTH-1:0] w_gray;

    assign w_s1_adv   = !r_s2_valid || bus_io.out_ready_i;
    // r_en keeps the input closed until the first clock after reset release.
    assign w_in_ready = r_en && (!r_s1_valid || w_s1_adv);
    assign w_in_fire  = bus_io.in_valid_i && w_in_ready;
    assign w_out_fire = r_s2_valid && bus_io.out_ready_i;

    // An SOF pixel already uses the mode it carries.
    assign w_mode_eff = bus_io.in_sof_i ? bus_io.mode_i : r_mode;

    assign w_r_x = TW'(bus_io.in_px_rgb_i[3*CH_WIDTH-1 -: CH_WIDTH]);
    assign w_g_x = TW'(bus_io.in_px_rgb_i[2*CH_WIDTH-1 -: CH_WIDTH]);
    assign w_b_x = TW'(bus_io.in_px_rgb_i[CH_WIDTH-1:0]);

    always_comb begin
        w_t_r = '0;
        w_t_g = '0;
        w_t_b = '0;
        case (w_mode_eff)
            2'd0: begin
                w_t_r = (w_r_x >> 2) + (w_r_x >> 5);
                w_t_g = (w_g_x >> 1) + (w_g_x >> 4);
                w_t_b = (w_b_x >> 4) + (w_b_x >> 5);
            end
            2'd1: begin
                w_t_r = (w_r_x >> 3) + (w_r_x >> 4) + (w_r_x >> 6);
                w_t_g = (w_g_x >> 1) + (w_g_x >> 3) + (w_g_x >> 4) + (w_g_x >> 6);
                w_t_b = (w_b_x >> 4) + (w_b_x >> 7);
            end
            2'd2: begin
                w_t_r = w_r_x;
                w_t_g = w_g_x;
                w_t_b = w_b_x;
            end
            default: begin
                w_t_g = w_g_x;
            end
        endcase
    end

    // Average mode: x*85/256 approximates x/3.
    assign w_sum      = SW'(r_s1_tr) + SW'(r_s1_tg) + SW'(r_s1_tb);
    assign w_avg_prod = PW'(w_sum) * PW'(85);
    assign w_pre      = r_s1_avg ? (w_avg_prod >> 8) : PW'(w_sum);
    assign w_sat      = (w_pre > SAT_MAX) ? {CH_WIDTH{1'b1}} : w_pre[CH_WIDTH-1:0];

    generate
        if (OUT_WIDTH < CH_WIDTH) begin : g_narrow
            assign w_gray = OUT_WIDTH'(w_sat >> (CH_WIDTH - OUT_WIDTH));
        end else if (OUT_WIDTH == CH_WIDTH) begin : g_same
            assign w_gray = w_sat;
        end else begin : g_wide
            assign w_gray = OUT_WIDTH'(w_sat) << (OUT_WIDTH - CH_WIDTH);
        end
    endgenerate

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_en   <= 1'b0;
            r_mode <= 2'd0;
        end else begin
            r_en <= 1'b1;
            if (w_in_fire && bus_io.in_sof_i) begin
                r_mode <= bus_io.mode_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_s1_valid <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s1_avg   <= 1'b0;
            r_s1_tr    <= '0;
            r_s1_tg    <= '0;
            r_s1_tb    <= '0;
        end else if (w_in_ready) begin
            r_s1_valid <= bus_io.in_valid_i;
            if (bus_io.in_valid_i) begin
                r_s1_sof <= bus_io.in_sof_i;
                r_s1_avg <= (w_mode_eff == 2'd2);
                r_s1_tr  <= w_t_r;
                r_s1_tg  <= w_t_g;
                r_s1_tb  <= w_t_b;
            end
        end
    end

    // Payload only loads with a valid pixel, so outputs hold through stalls.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_s2_valid <= 1'b0;
            r_s2_sof   <= 1'b0;
            r_s2_gray  <= '0;
        end else if (w_s1_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sof  <= r_s1_sof;
                r_s2_gray <= w_gray;
            end
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_cnt <= '0;
        end else if (w_out_fire) begin
            r_cnt <= r_s2_sof ? CNT_WIDTH'(1) : r_cnt + CNT_WIDTH'(1);
        end
    end

    assign bus_io.in_ready_o    = w_in_ready;
    assign bus_io.out_valid_o   = r_s2_valid;
    assign bus_io.out_sof_o     = r_s2_sof;
    assign bus_io.out_px_gray_o = r_s2_gray;
    assign bus_io.px_count_o    = r_cnt;
    assign bus_io.mode_o        = r_mode;
endmodule

// File: tb/tb_gray_scale_pipe.sv
// Bench for gray_scale_pipe: default-width instance driven through a scoreboard,
// plus a 10-bit-channel / 4-bit-counter instance for width and wrap behaviour.
module tb_gray_scale_pipe;
    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    gray_scale_pipe_if #(.CH_WIDTH(8),  .OUT_WIDTH(8), .CNT_WIDTH(16)) bus_a ();
    gray_scale_pipe_if #(.CH_WIDTH(10), .OUT_WIDTH(8), .CNT_WIDTH(4))  bus_b ();

    gray_scale_pipe #(.CH_WIDTH(8), .OUT_WIDTH(8), .CNT_WIDTH(16)) dut_a (
        .clk_i    (clk),
        .nreset_i (nreset),
        .bus_io   (bus_a)
    );

    gray_scale_pipe #(.CH_WIDTH(10), .OUT_WIDTH(8), .CNT_WIDTH(4)) dut_b (
        .clk_i    (clk),
        .nreset_i (nreset),
        .bus_io   (bus_b)
    );

    typedef struct {
        int gray;
        bit sof;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q_a[$];
    int   cnt_m = 0;
    int   mode_m = 0;
    bit   mon_on = 1'b0;
    int   stall_hits = 0;

    function automatic int model_gray(input int ch, input int ow, input int mode,
                                      input int r, input int g, input int b);
        int s;
        int mx;
        case (mode)
            0: s = (r >> 2) + (r >> 5) + (g >> 1) + (g >> 4) + (b >> 4) + (b >> 5);
            1: s = (r >> 3) + (r >> 4) + (r >> 6) + (g >> 1) + (g >> 3) + (g >> 4)
                 + (g >> 6) + (b >> 4) + (b >> 7);
            2: s = ((r + g + b) * 85) >> 8;
            default: s = g;
        endcase
        mx = (1 << ch) - 1;
        if (s > mx) s = mx;
        if (ow < ch) s = s >> (ch - ow);
        else s = s << (ow - ch);
        return s;
    endfunction

    // Scoreboard for instance A, sampled mid-cycle.
    always @(negedge clk) begin : mon_a
        bit   exp_rdy;
        exp_t e;
        if (mon_on && nreset) begin
            n_vec++;
            if (bus_a.mode_o !== 2'(mode_m)) begin
                n_err++;
                $display("FAIL mode_o: got %0d want %0d", bus_a.mode_o, mode_m);
            end
            exp_rdy = !(q_a.size() == 2 && !bus_a.out_ready_i);
            if (q_a.size() == 2 && !bus_a.out_ready_i) stall_hits++;
            n_vec++;
            if (bus_a.in_ready_o !== exp_rdy) begin
                n_err++;
                $display("FAIL in_ready: got %0b want %0b", bus_a.in_ready_o, exp_rdy);
            end
            n_vec++;
            if (bus_a.px_count_o !== 16'(cnt_m)) begin
                n_err++;
                $display("FAIL px_count: got %0d want %0d", bus_a.px_count_o, cnt_m);
            end
            if (bus_a.out_valid_o) begin
                n_vec++;
                if (q_a.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out: got gray %0d want no pixel",
                             bus_a.out_px_gray_o);
                end else begin
                    e = q_a[0];
                    if (bus_a.out_px_gray_o !== 8'(e.gray) || bus_a.out_sof_o !== e.sof) begin
                        n_err++;
                        $display("FAIL out_pixel: got gray %0d sof %0b want gray %0d sof %0b",
                                 bus_a.out_px_gray_o, bus_a.out_sof_o, e.gray, e.sof);
                    end
                    if (bus_a.out_ready_i) begin
                        void'(q_a.pop_front());
                        cnt_m = e.sof ? 1 : ((cnt_m + 1) % 65536);
                    end
                end
            end
            if (bus_a.in_valid_i && bus_a.in_ready_o) begin
                if (bus_a.in_sof_i) mode_m = int'(bus_a.mode_i);
                e.gray = model_gray(8, 8, mode_m, int'(bus_a.in_px_rgb_i[23:16]),
                                    int'(bus_a.in_px_rgb_i[15:8]), int'(bus_a.in_px_rgb_i[7:0]));
                e.sof  = bus_a.in_sof_i;
                q_a.push_back(e);
            end
        end
    end

    task automatic idle_a();
        bus_a.in_valid_i = 1'b0;
        bus_a.in_sof_i   = 1'b0;
    endtask

    task automatic send_a(input bit sof, input int mode, input int r, input int g, input int b);
        bit acc;
        bit done;
        done = 1'b0;
        bus_a.in_valid_i  = 1'b1;
        bus_a.in_sof_i    = sof;
        bus_a.mode_i      = 2'(mode);
        bus_a.in_px_rgb_i = {8'(r), 8'(g), 8'(b)};
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            acc = bus_a.in_ready_o;
            @(posedge clk);
            #1;
            if (acc) done = 1'b1;
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL send_timeout: got no accept want accept within 50 cycles");
        end
    endtask

    task automatic wait_out_a(output int gray, output bit sof, output bit ok);
        ok = 1'b0;
        gray = -1;
        sof = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (bus_a.out_valid_o && bus_a.out_ready_i) begin
                ok   = 1'b1;
                gray = int'(bus_a.out_px_gray_o);
                sof  = bus_a.out_sof_o;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain_a();
        int k;
        k = 0;
        bus_a.out_ready_i = 1'b1;
        while (q_a.size() != 0 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_vec++;
        if (q_a.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", q_a.size());
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        #3;
        n_vec++;
        if (bus_a.out_valid_o !== 1'b0 || bus_a.out_px_gray_o !== 8'd0 || bus_a.out_sof_o !== 1'b0
            || bus_a.px_count_o !== 16'd0 || bus_a.mode_o !== 2'd0 || bus_a.in_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got v%0b g%0d s%0b c%0d m%0d r%0b want all 0",
                     bus_a.out_valid_o, bus_a.out_px_gray_o, bus_a.out_sof_o,
                     bus_a.px_count_o, bus_a.mode_o, bus_a.in_ready_o);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        #1;
        n_vec++;
        if (bus_a.in_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL ready_at_release: got %0b want 0", bus_a.in_ready_o);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (bus_a.in_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_edge: got %0b want 1", bus_a.in_ready_o);
        end
        q_a.delete();
        cnt_m = 0;
        mode_m = 0;
        mon_on = 1'b1;
    endtask

    task automatic test_bt601();
        bus_a.out_ready_i = 1'b1;
        bus_a.in_valid_i  = 1'b1;
        bus_a.in_sof_i    = 1'b1;
        bus_a.mode_i      = 2'd0;
        bus_a.in_px_rgb_i = {8'd200, 8'd100, 8'd50};
        @(posedge clk);
        #1;
        idle_a();
        n_vec++;
        if (bus_a.out_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early: got valid %0b want 0", bus_a.out_valid_o);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (bus_a.out_valid_o !== 1'b1 || bus_a.out_px_gray_o !== 8'd116 || bus_a.out_sof_o !== 1'b1) begin
            n_err++;
            $display("FAIL bt601: got v%0b gray %0d sof %0b want v1 gray 116 sof 1",
                     bus_a.out_valid_o, bus_a.out_px_gray_o, bus_a.out_sof_o);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (bus_a.px_count_o !== 16'd1) begin
            n_err++;
            $display("FAIL bt601_count: got %0d want 1", bus_a.px_count_o);
        end
    endtask

    task automatic test_modes();
        int g;
        bit s;
        bit ok;
        int want[4] = '{112, 241, 254, 77};
        bit want_sof[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: send_a(1'b1, 1, 200, 100, 50);
                1: send_a(1'b0, 3, 255, 255, 255);
                2: send_a(1'b1, 2, 255, 255, 255);
                default: send_a(1'b1, 3, 10, 77, 200);
            endcase
            idle_a();
            wait_out_a(g, s, ok);
            n_vec++;
            if (!ok || g != want[i] || s != want_sof[i]) begin
                n_err++;
                $display("FAIL mode_case%0d: got ok %0b gray %0d sof %0b want gray %0d sof %0b",
                         i, ok, g, s, want[i], want_sof[i]);
            end
            if (i == 1) begin
                n_vec++;
                if (bus_a.mode_o !== 2'd1) begin
                    n_err++;
                    $display("FAIL mode_hold: got %0d want 1", bus_a.mode_o);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        stall_hits = 0;
        fork
            begin
                send_a(1'b1, 1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
                for (int p = 1; p < 8; p++) begin
                    send_a(1'b0, $urandom_range(0, 3), $urandom_range(0, 255),
                           $urandom_range(0, 255), $urandom_range(0, 255));
                end
                idle_a();
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    bus_a.out_ready_i = (c % 3 == 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        drain_a();
        n_vec++;
        if (bus_a.px_count_o !== 16'd8) begin
            n_err++;
            $display("FAIL stream_count: got %0d want 8", bus_a.px_count_o);
        end
        n_vec++;
        if (stall_hits == 0) begin
            n_err++;
            $display("FAIL stall_seen: got 0 full stalls want at least 1");
        end
    endtask

    task automatic test_reset_mid();
        int n_bad;
        bus_a.out_ready_i = 1'b0;
        send_a(1'b1, 2, 90, 180, 30);
        send_a(1'b0, 1, 40, 50, 60);
        idle_a();
        mon_on = 1'b0;
        #2;
        nreset = 1'b0;
        #1;
        n_vec++;
        if (bus_a.out_valid_o !== 1'b0 || bus_a.out_px_gray_o !== 8'd0 || bus_a.out_sof_o !== 1'b0
            || bus_a.px_count_o !== 16'd0 || bus_a.mode_o !== 2'd0 || bus_a.in_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_outputs: got v%0b g%0d s%0b c%0d m%0d r%0b want all 0",
                     bus_a.out_valid_o, bus_a.out_px_gray_o, bus_a.out_sof_o,
                     bus_a.px_count_o, bus_a.mode_o, bus_a.in_ready_o);
        end
        @(posedge clk);
        #1;
        nreset = 1'b1;
        q_a.delete();
        cnt_m = 0;
        mode_m = 0;
        bus_a.out_ready_i = 1'b1;
        n_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_a.out_valid_o) n_bad++;
        end
        n_vec++;
        if (n_bad != 0 || bus_a.mode_o !== 2'd0) begin
            n_err++;
            $display("FAIL stale_after_reset: got %0d valids mode %0d want 0 valids mode 0",
                     n_bad, bus_a.mode_o);
        end
        @(posedge clk);
        #1;
        mon_on = 1'b1;
    endtask

    task automatic test_params();
        int n_out;
        int grays[18];
        bit first_sof;
        n_out = 0;
        first_sof = 1'b0;
        bus_b.out_ready_i = 1'b1;
        bus_b.mode_i = 2'd3;
        for (int k = 0; k < 26; k++) begin
            bus_b.in_valid_i  = (k < 18);
            bus_b.in_sof_i    = (k == 0);
            bus_b.in_px_rgb_i = {10'd0, (k == 0) ? 10'd1023 : 10'(k * 37), 10'd1023};
            @(negedge clk);
            if (bus_b.out_valid_o) begin
                if (n_out == 0) first_sof = bus_b.out_sof_o;
                if (n_out < 18) grays[n_out] = int'(bus_b.out_px_gray_o);
                n_out++;
            end
            @(posedge clk);
            #1;
        end
        n_vec++;
        if (n_out != 18) begin
            n_err++;
            $display("FAIL wide_outputs: got %0d want 18", n_out);
        end
        n_vec++;
        if (grays[0] != 255 || !first_sof) begin
            n_err++;
            $display("FAIL wide_sat: got %0d sof %0b want 255 sof 1", grays[0], first_sof);
        end
        n_vec++;
        if (grays[1] != model_gray(10, 8, 3, 0, 37, 1023) || grays[1] != 9) begin
            n_err++;
            $display("FAIL wide_trunc: got %0d want 9", grays[1]);
        end
        n_vec++;
        if (bus_b.px_count_o !== 4'd2) begin
            n_err++;
            $display("FAIL count_wrap: got %0d want 2", bus_b.px_count_o);
        end
    endtask

    initial begin
        nreset = 1'b0;
        bus_a.in_valid_i = 1'b0;
        bus_a.in_sof_i = 1'b0;
        bus_a.in_px_rgb_i = '0;
        bus_a.mode_i = 2'd0;
        bus_a.out_ready_i = 1'b1;
        bus_b.in_valid_i = 1'b0;
        bus_b.in_sof_i = 1'b0;
        bus_b.in_px_rgb_i = '0;
        bus_b.mode_i = 2'd0;
        bus_b.out_ready_i = 1'b1;
        test_reset();
        test_bt601();
        test_modes();
        test_backpressure();
        test_reset_mid();
        test_params();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before 500000");
        $fatal(1, "watchdog expired");
    end
endmodule
